// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - keypad matrix and debounced key output bundle
//
// Purpose: groups the keypad matrix lines and the debounced key result of one
//          keypad_scanner instance.
// Signals:
//   rows_n      4  keypad rows, pulled up, low = contact (keypad -> scanner)
//   cols_n      4  one-hot active-low column drive (scanner -> keypad)
//   keys        4  debounced key code (scanner -> consumer)
//   keypressed  1  high while a debounced key is held (scanner -> consumer)
// Modports: master = scanner side, slave = keypad/consumer side.

interface keypad_scanner_if;
   logic [3:0] rows_n;
   logic [3:0] cols_n;
   logic [3:0] keys;
   logic       keypressed;

   modport master (
      input  rows_n,
      output cols_n,
      output keys,
      output keypressed
   );

   modport slave (
      output rows_n,
      input  cols_n,
      input  keys,
      input  keypressed
   );
endinterface

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with synchroniser and debounce
//
// Purpose: drives the keypad columns one at a time, samples the synchronised
//          rows after a settle time, picks the highest-priority pressed key per
//          full scan and publishes it once it is stable for DEBOUNCE_SCANS scans.
// Ports:
//   CLOCK_25  in   system clock (25 MHz)
//   reset     in   synchronous reset, active high
//   kp        master modport: rows_n in, cols_n/keys/keypressed out (registered)

module keypad_scanner #(
   parameter int SETTLE_CYCLES  = 1250,
   parameter int DEBOUNCE_SCANS = 16
) (
   input  logic             CLOCK_25,
   input  logic             reset,
   keypad_scanner_if.master kp
);

   localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
   localparam logic [DW-1:0] CNT_MAX     = DW'(DEBOUNCE_SCANS);
   localparam logic [DW-1:0] CNT_FIRE    = DW'(DEBOUNCE_SCANS - 1);

   typedef enum logic [1:0] {
      COL0 = 2'd0,
      COL1 = 2'd1,
      COL2 = 2'd2,
      COL3 = 2'd3
   } col_state_t;

   col_state_t      state;
   col_state_t      state_next;
   logic [SW-1:0]   settle;
   logic [3:0]      rows_meta;
   logic [3:0]      rows_s;

   logic            cand_valid;
   logic [3:0]      cand_code;
   logic            prev_valid;
   logic [3:0]      prev_code;
   logic [DW-1:0]   cnt;

   logic            apply_pend;
   logic            apply_valid;
   logic [3:0]      apply_code;

   logic            hit;
   logic [1:0]      hit_row;
   logic [1:0]      col_idx;
   logic [1:0]      next_idx;
   logic [3:0]      hit_code;
   logic            res_valid;
   logic [3:0]      res_code;

   // Phone-layout code for the key at (row, col).
   function automatic logic [3:0] code_of(input logic [1:0] row, input logic [1:0] col);
      logic [3:0] c;
      case ({row, col})
         4'h0: c = 4'd1;
         4'h1: c = 4'd2;
         4'h2: c = 4'd3;
         4'h3: c = 4'd10;
         4'h4: c = 4'd4;
         4'h5: c = 4'd5;
         4'h6: c = 4'd6;
         4'h7: c = 4'd11;
         4'h8: c = 4'd7;
         4'h9: c = 4'd8;
         4'hA: c = 4'd9;
         4'hB: c = 4'd12;
         4'hC: c = 4'd14;
         4'hD: c = 4'd0;
         4'hE: c = 4'd15;
         4'hF: c = 4'd13;
      endcase
      return c;
   endfunction

   always_comb begin
      state_next = COL0;
      case (state)
         COL0:    state_next = COL1;
         COL1:    state_next = COL2;
         COL2:    state_next = COL3;
         COL3:    state_next = COL0;
         default: state_next = COL0;
      endcase
   end

   assign col_idx  = state;
   assign next_idx = state_next;

   // Lowest pressed row in the driven column; descending loop lets row 0 win.
   always_comb begin
      hit     = 1'b0;
      hit_row = 2'd0;
      for (int r = 3; r >= 0; r--) begin
         if (!rows_s[r]) begin
            hit     = 1'b1;
            hit_row = 2'(r);
         end
      end
   end

   assign hit_code = code_of(hit_row, col_idx);

   // Full-scan result as seen at the COL3 sample; an earlier column always wins.
   // "none" carries code 0 so that result comparison is a plain equality.
   assign res_valid = cand_valid | hit;
   assign res_code  = cand_valid ? cand_code : (hit ? hit_code : 4'd0);

   always_ff @(posedge CLOCK_25) begin
      if (reset) begin
         rows_meta     <= 4'hF;
         rows_s        <= 4'hF;
         state         <= COL0;
         settle        <= '0;
         cand_valid    <= 1'b0;
         cand_code     <= 4'd0;
         prev_valid    <= 1'b0;
         prev_code     <= 4'd0;
         cnt           <= '0;
         apply_pend    <= 1'b0;
         apply_valid   <= 1'b0;
         apply_code    <= 4'd0;
         kp.cols_n     <= 4'b1110;
         kp.keys       <= 4'd0;
         kp.keypressed <= 1'b0;
      end else begin
         rows_meta  <= kp.rows_n;
         rows_s     <= rows_meta;
         apply_pend <= 1'b0;

         // Outputs follow the debounce decision by one cycle; a "none" event
         // drops keypressed but keeps the last code on keys.
         if (apply_pend) begin
            if (apply_valid) begin
               kp.keys       <= apply_code;
               kp.keypressed <= 1'b1;
            end else begin
               kp.keypressed <= 1'b0;
            end
         end

         if (settle == SETTLE_LAST) begin
            settle    <= '0;
            state     <= state_next;
            kp.cols_n <= ~(4'b0001 << next_idx);

            if (state == COL3) begin
               cand_valid <= 1'b0;
               cand_code  <= 4'd0;
               if ({res_valid, res_code} == {prev_valid, prev_code}) begin
                  if (cnt != CNT_MAX) begin
                     cnt <= cnt + 1'b1;
                  end
                  // Fire only on the transition into saturation.
                  if (cnt == CNT_FIRE) begin
                     apply_pend  <= 1'b1;
                     apply_valid <= res_valid;
                     apply_code  <= res_code;
                  end
               end else begin
                  cnt        <= DW'(1);
                  prev_valid <= res_valid;
                  prev_code  <= res_code;
               end
            end else if (!cand_valid && hit) begin
               cand_valid <= 1'b1;
               cand_code  <= hit_code;
            end
         end else begin
            settle <= settle + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - randomized self-checking bench for keypad_scanner

module tb_keypad_scanner;

   localparam int SETTLE = 4;
   localparam int DEB    = 3;
   localparam int SCAN   = 4 * SETTLE;

   logic CLOCK_25 = 1'b0;
   logic reset    = 1'b1;

   keypad_scanner_if kif();

   keypad_scanner #(
      .SETTLE_CYCLES (SETTLE),
      .DEBOUNCE_SCANS(DEB)
   ) dut (
      .CLOCK_25(CLOCK_25),
      .reset   (reset),
      .kp      (kif)
   );

   always #20 CLOCK_25 = ~CLOCK_25;

   // Pressed-key matrix: bit r*4+c is the key at row r, column c.
   logic [15:0] mat = 16'h0000;

   // Passive keypad: a row reads low when a pressed key joins it to a driven column.
   always_comb begin
      kif.rows_n = 4'hF;
      for (int r = 0; r < 4; r++) begin
         kif.rows_n[r] = ~|(mat[r*4 +: 4] & ~kif.cols_n);
      end
   end

   int code_tab[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

   int vectors     = 0;
   int miscompares = 0;

   // Reference model state: edges since reset, per-scan results (-1 = none).
   int n        = 0;
   int hist[$];
   int m_keys   = 0;
   int m_kp     = 0;
   bit pend     = 1'b0;
   int pend_res = 0;

   function automatic int winner(logic [15:0] m);
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            if (m[r*4 + c]) return code_tab[r*4 + c];
         end
      end
      return -1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s at edge %0d: got %0d, expected %0d", tag, n, got, exp);
      end
   endtask

   // One clock edge, model update, then check all outputs on the falling edge.
   task automatic step(input bit rst);
      reset = rst;
      @(posedge CLOCK_25);
      if (rst) begin
         n      = 0;
         hist.delete();
         m_keys = 0;
         m_kp   = 0;
         pend   = 1'b0;
      end else begin
         n++;
         if (pend) begin
            if (pend_res >= 0) begin
               m_keys = pend_res;
               m_kp   = 1;
            end else begin
               m_kp = 0;
            end
            pend = 1'b0;
         end
         if (n % SCAN == 0) begin
            int res;
            int run;
            res = winner(mat);
            hist.push_back(res);
            run = 0;
            for (int i = hist.size() - 1; i >= 0 && hist[i] == res; i--) run++;
            if (run == DEB) begin
               pend     = 1'b1;
               pend_res = res;
            end
         end
      end
      @(negedge CLOCK_25);
      chk("cols_n", 32'(kif.cols_n), 32'(15 - (1 << ((n / SETTLE) % 4))));
      chk("keys", 32'(kif.keys), 32'(m_keys));
      chk("keypressed", 32'(kif.keypressed), 32'(m_kp));
   endtask

   // Matrix changes only at scan boundaries so every scan sees one pattern.
   task automatic hold(input logic [15:0] m, input int scans);
      mat = m;
      repeat (scans * SCAN) step(1'b0);
   endtask

   initial begin
      logic [15:0] nm;

      repeat (3) step(1'b1);

      hold(16'h0002, 5);              // "2" held from reset release
      hold(16'h0000, 4);              // release: keys stays 2
      hold(16'h0200, 1);              // "8" bounce for one scan
      hold(16'h0000, 4);
      hold(16'h0002, 4);              // "2" then "8" without release
      hold(16'h0200, 4);
      hold(16'h0000, 4);
      hold(16'h0820, 4);              // "5" + "C": column 1 wins
      hold(16'h0800, 4);              // "C" alone

      repeat (9) step(1'b0);          // into COL2 with keypressed high
      step(1'b1);
      hold(16'h0800, 4);

      for (int e = 0; e < 60; e++) begin
         case ($urandom_range(0, 4))
            0:       nm = 16'h0000;
            1:       nm = 16'(1) << $urandom_range(0, 15);
            2:       nm = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
            3:       nm = 16'($urandom);
            default: nm = mat;
         endcase
         hold(nm, $urandom_range(1, 5));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
